mem_req_ctrl: RTL

Sequencer between the dual-issue EX stage and the single data-SRAM-like memory port. It issues line1 and line2 memory requests of an EX bundle in program order and throttles outstanding transactions. It tags every accepted request so that responses belonging to an exception-flushed bundle are discarded instead of reaching MEM/WB. It sits beside the EX→MEM pipeline register and drives its EX-side allowin and the MEM-side read-data-valid/cancel information.

---
 rtl/mem_req_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: orders the line1/line2 memory requests of an EX bundle onto one
// data-SRAM port and tags in-flight transactions so flushed responses are dropped.
// Optional macro MEM_REQ_CTRL_RESP_REG_EN registers the response outputs.
module mem_req_ctrl #(
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        excep_flush_i,
    input  logic        ex_valid_i,
    input  logic        line1_req_i,
    input  logic        line1_we_i,
    input  logic [1:0]  line1_size_i,
    input  logic [31:0] line1_addr_i,
    input  logic [31:0] line1_wdata_i,
    input  logic [3:0]  line1_wstrb_i,
    input  logic        line2_req_i,
    input  logic        line2_we_i,
    input  logic [1:0]  line2_size_i,
    input  logic [31:0] line2_addr_i,
    input  logic [31:0] line2_wdata_i,
    input  logic [3:0]  line2_wstrb_i,
    output logic        ex_mem_done_o,
    output logic        data_sram_req_o,
    output logic        data_sram_wr_o,
    output logic [1:0]  data_sram_size_o,
    output logic [31:0] data_sram_addr_o,
    output logic [31:0] data_sram_wdata_o,
    output logic [3:0]  data_sram_wstrb_o,
    input  logic        data_sram_addr_ok_i,
    input  logic        data_sram_data_ok_i,
    input  logic [31:0] data_sram_rdata_i,
    output logic        resp_valid_o,
    output logic        resp_line_o,
    output logic        resp_we_o,
    output logic [31:0] resp_rdata_o,
    output logic [2:0]  outstanding_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] LAST = 2'(MAX_OUT - 1);
    localparam logic [2:0] FULL = 3'(MAX_OUT);

    state_t      state;
    logic        cur_line;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        full;
    logic        accept;
    logic        pop;
    logic        load_l1;
    logic        load_l2;
    logic        enq_cancel;

    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        tag_line   [0:3];
    logic        tag_we     [0:3];
    logic        tag_cancel [0:3];

    logic        head_line;
    logic        head_we;
    logic        head_cancel;
    logic        resp_fire;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue handshake, field capture selects and bundle completion.
    always_comb begin
        full        = (count == FULL);
        data_sram_req_o = (state != IDLE) && !full;
        accept      = data_sram_req_o && data_sram_addr_ok_i;
        pop         = data_sram_data_ok_i && (count != 3'd0);
        enq_cancel  = excep_flush_i || (state == HOLD);
        load_l1     = (state == IDLE) && !excep_flush_i
                      && ex_valid_i && line1_req_i;
        load_l2     = !excep_flush_i
                      && (((state == IDLE) && ex_valid_i
                           && !line1_req_i && line2_req_i)
                          || ((state == L1) && accept && line2_req_i));
        ex_mem_done_o = 1'b0;
        if (!excep_flush_i) begin
            unique case (state)
                IDLE: ex_mem_done_o = ex_valid_i
                                      && !line1_req_i && !line2_req_i;
                L1:   ex_mem_done_o = accept && !line2_req_i;
                L2:   ex_mem_done_o = accept;
                HOLD: ex_mem_done_o = 1'b0;
                default: ex_mem_done_o = 1'b0;
            endcase
        end
    end

    // Issue FSM with registered request fields held until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_line <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_l1) begin
                        state <= L1;
                    end else if (load_l2) begin
                        state <= L2;
                    end
                end
                L1, L2: begin
                    if (excep_flush_i) begin
                        if (data_sram_req_o && !accept) begin
                            state <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        state <= load_l2 ? L2 : IDLE;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load_l1) begin
                cur_line <= 1'b0;
                wr_q     <= line1_we_i;
                size_q   <= line1_size_i;
                addr_q   <= line1_addr_i;
                wdata_q  <= line1_wdata_i;
                wstrb_q  <= line1_wstrb_i;
            end else if (load_l2) begin
                cur_line <= 1'b1;
                wr_q     <= line2_we_i;
                size_q   <= line2_size_i;
                addr_q   <= line2_addr_i;
                wdata_q  <= line2_wdata_i;
                wstrb_q  <= line2_wstrb_i;
            end
        end
    end

    assign data_sram_wr_o    = wr_q;
    assign data_sram_size_o  = size_q;
    assign data_sram_addr_o  = addr_q;
    assign data_sram_wdata_o = wdata_q;
    assign data_sram_wstrb_o = wstrb_q;

    // Tag FIFO: push on accept, pop on data_ok, flush cancels everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                tag_line[i]   <= 1'b0;
                tag_we[i]     <= 1'b0;
                tag_cancel[i] <= 1'b0;
            end
        end else begin
            if (excep_flush_i) begin
                for (int i = 0; i < 4; i++) begin
                    tag_cancel[i] <= 1'b1;
                end
            end
            if (accept) begin
                tag_line[wr_ptr]   <= cur_line;
                tag_we[wr_ptr]     <= wr_q;
                tag_cancel[wr_ptr] <= enq_cancel;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign outstanding_o = count;
    assign head_line     = tag_line[rd_ptr];
    assign head_we       = tag_we[rd_ptr];
    assign head_cancel   = tag_cancel[rd_ptr];
    assign resp_fire     = pop && !head_cancel && !excep_flush_i;

`ifdef MEM_REQ_CTRL_RESP_REG_EN
    logic        rv_q;
    logic        rl_q;
    logic        rw_q;
    logic [31:0] rd_q;

    // Registered response stage, one cycle behind data_ok.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv_q <= 1'b0;
            rl_q <= 1'b0;
            rw_q <= 1'b0;
            rd_q <= 32'd0;
        end else begin
            rv_q <= resp_fire;
            if (resp_fire) begin
                rl_q <= head_line;
                rw_q <= head_we;
                rd_q <= data_sram_rdata_i;
            end
        end
    end

    assign resp_valid_o = rv_q;
    assign resp_line_o  = rl_q;
    assign resp_we_o    = rw_q;
    assign resp_rdata_o = rd_q;
`else
    assign resp_valid_o = resp_fire;
    assign resp_line_o  = resp_fire ? head_line : 1'b0;
    assign resp_we_o    = resp_fire ? head_we : 1'b0;
    assign resp_rdata_o = resp_fire ? data_sram_rdata_i : 32'd0;
`endif

endmodule
